noise_vector_sequencer: RTL and testbench

Controller that sequences the LFSR noise generator to produce fixed-length latent noise vectors for the generator network input. It drives the noise generator's enable and optionally discards a programmable number of leading samples for decorrelation. It buffers returned samples in a 2-entry FIFO and presents them as a backpressured stream with an end-of-vector marker. One vector is produced per `start` pulse.

---
 rtl/noise_vector_sequencer.sv | 165 ++++++++++++++++
 tb/tb_noise_vector_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_vector_sequencer.sv
// Sequences an LFSR noise generator into fixed-length, backpressured sample vectors,
// discarding an optional run of leading samples and buffering returns in a 2-entry FIFO.
module noise_vector_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 10,
    parameter int SKIP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  vec_len,
    input  logic [SKIP_WIDTH-1:0] skip_len,
    output logic                  busy,
    output logic                  done,
    output logic                  noise_en,
    input  logic [DATA_WIDTH-1:0] noise_in,
    input  logic                  noise_valid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_vec_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [SKIP_WIDTH-1:0] r_skip_len;
    logic [SKIP_WIDTH-1:0] r_skip_cnt;
    logic                  r_infl;
    logic                  r_skip_flag;
    logic                  r_busy;
    logic                  r_done;

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;

    logic w_pop;
    logic w_push;
    logic w_room;
    logic w_data_issue;
    logic w_skip_issue;

    assign m_tvalid = (r_occ != 2'd0);
    assign m_tdata  = r_mem[r_rd_ptr];
    assign m_tlast  = m_tvalid && (r_beat == r_vec_len - LEN_WIDTH'(1));
    assign w_pop    = m_tvalid & m_tready;
    assign w_push   = noise_valid & ~r_skip_flag;

    // Count the sample still in flight from last cycle so the FIFO can never overflow.
    assign w_room       = ({1'b0, r_occ} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop});
    assign w_data_issue = (r_state == S_STREAM) && (r_issued < r_vec_len) && w_room;
    assign w_skip_issue = (r_state == S_SKIP);
    assign noise_en     = w_data_issue | w_skip_issue;

    assign busy = r_busy;
    assign done = r_done;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_vec_len   <= '0;
            r_skip_len  <= '0;
            r_issued    <= '0;
            r_skip_cnt  <= '0;
            r_beat      <= '0;
            r_infl      <= 1'b0;
            r_skip_flag <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_infl      <= w_data_issue;
            r_skip_flag <= w_skip_issue;

            if (r_state == S_IDLE) begin
                r_beat <= '0;
            end else if (w_pop) begin
                r_beat <= r_beat + LEN_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_issued   <= '0;
                    r_skip_cnt <= '0;
                    if (start) begin
                        if (vec_len != '0) begin
                            r_vec_len  <= vec_len;
                            r_skip_len <= skip_len;
                            r_busy     <= 1'b1;
                            r_state    <= (skip_len != '0) ? S_SKIP : S_STREAM;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_SKIP: begin
                    r_skip_cnt <= r_skip_cnt + SKIP_WIDTH'(1);
                    if (r_skip_cnt == r_skip_len - SKIP_WIDTH'(1)) begin
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_data_issue) begin
                        r_issued <= r_issued + LEN_WIDTH'(1);
                        if (r_issued == r_vec_len - LEN_WIDTH'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && m_tlast) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: the two FIFO entries are reset as well, so m_tdata reads 0 out of reset;
    // large memories would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= noise_in;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_noise_vector_sequencer.sv
// Scoreboard bench for noise_vector_sequencer: a behavioural LFSR generator feeds the DUT,
// expected beats are queued at start, and a negedge monitor pops and compares each handshake.
module tb_noise_vector_sequencer;

    localparam int DW = 16;
    localparam int LW = 10;
    localparam int SW = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] vec_len = '0;
    logic [SW-1:0] skip_len = '0;
    logic          busy, done, noise_en;
    logic [DW-1:0] noise_in;
    logic          noise_valid;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast;
    logic          m_tready = 1'b0;

    always #5 clk = ~clk;

    noise_vector_sequencer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .SKIP_WIDTH(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .vec_len    (vec_len),
        .skip_len   (skip_len),
        .busy       (busy),
        .done       (done),
        .noise_en   (noise_en),
        .noise_in   (noise_in),
        .noise_valid(noise_valid),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {1'b0, x[15:1]} ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Generator output #k after reset (k >= 1).
    function automatic logic [15:0] lfsr_nth(input int k);
        logic [15:0] x;
        x = SEED;
        for (int i = 0; i < k; i++) x = lfsr_step(x);
        return x;
    endfunction

    // Behavioural noise generator: valid one cycle after each enable, shares rst_n.
    logic [15:0] gen_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_lfsr    <= SEED;
            noise_valid <= 1'b0;
            noise_in    <= '0;
        end else begin
            noise_valid <= noise_en;
            if (noise_en) begin
                gen_lfsr <= lfsr_step(gen_lfsr);
                noise_in <= lfsr_step(gen_lfsr);
            end
        end
    end

    typedef struct {
        logic [15:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int gen_idx = 0;
    int tready_mode = 0;

    int t0 = 0;
    int en_cnt = 0;
    int beats = 0;
    int lasts = 0;
    int first_valid = -1;
    int last_off = -1;
    int done_off = -1;
    int done_cnt = 0;
    int outstanding = 0;
    int cur_skip = 0;
    bit busy_seen = 1'b0;

    logic mon_pop;
    logic mon_issue;
    beat_t mon_exp;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples mid-cycle, checks issue room and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
        end else begin
            mon_pop   = m_tvalid & m_tready;
            mon_issue = noise_en && (en_cnt >= cur_skip);
            if (mon_issue) check("issue_room", int'((outstanding - int'(mon_pop)) < 2), 1);
            if (noise_en) en_cnt++;
            outstanding = outstanding + int'(mon_issue) - int'(mon_pop);
            if (busy) busy_seen = 1'b1;
            if (m_tvalid && first_valid < 0) first_valid = cyc - t0;
            if (done) begin
                done_cnt++;
                if (done_off < 0) done_off = cyc - t0;
            end
            if (mon_pop) begin
                beats++;
                if (m_tlast) begin
                    lasts++;
                    last_off = cyc - t0;
                end
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL beat_unexpected: got data 0x%0h, expected no beat at cycle %0d",
                             m_tdata, cyc);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat_data", int'(m_tdata), int'(mon_exp.data));
                    check("beat_last", int'(m_tlast), int'(mon_exp.last));
                end
            end
        end
    end

    // Downstream ready: 0 = always high, 1 = random with a 10-cycle low window, 2 = low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ((cyc - t0) >= 6 && (cyc - t0) < 16) ? 1'b0
                                    : 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_noise_en"}, int'(noise_en), 0);
        check({tag, "_tvalid"}, int'(m_tvalid), 0);
        check({tag, "_tlast"}, int'(m_tlast), 0);
        check({tag, "_tdata"}, int'(m_tdata), 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tready_mode = 0;
        gen_idx = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("post_reset");
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after done.
    task automatic run_vector(input int len, input int skip, input int mode,
                              input bit chk_t, input bit mid);
        tready_mode = mode;
        start    = 1'b1;
        vec_len  = LW'(len);
        skip_len = SW'(skip);
        t0 = cyc;
        en_cnt = 0;
        beats = 0;
        lasts = 0;
        first_valid = -1;
        last_off = -1;
        done_off = -1;
        done_cnt = 0;
        busy_seen = 1'b0;
        cur_skip = skip;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back('{data: lfsr_nth(gen_idx + skip + i + 1), last: (i == len - 1)});
        end
        if (len != 0) gen_idx += skip + len;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 600 && done_off < 0; n++) begin
            if (mid && (cyc - t0) == 5) begin
                start    = 1'b1;
                vec_len  = LW'(3);
                skip_len = SW'(0);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("done_seen", int'(done_off >= 0), 1);
        check("done_pulses", done_cnt, 1);
        check("q_drained", exp_q.size(), 0);
        exp_q.delete();
        if (len == 0) begin
            check("zero_done_off", done_off, 1);
            check("zero_en_cnt", en_cnt, 0);
            check("zero_busy", int'(busy_seen), 0);
            check("zero_beats", beats, 0);
        end else begin
            check("en_cnt", en_cnt, skip + len);
            check("beats", beats, len);
            check("tlast_cnt", lasts, 1);
            check("done_after_last", done_off, last_off + 1);
            if (chk_t) begin
                check("first_valid_off", first_valid, 3 + skip);
                check("tlast_off", last_off, 2 + skip + len);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset();

        // Basic vector: data are generator outputs #1..#4, beats T+3..T+6, done T+7.
        run_vector(4, 0, 0, 1'b1, 1'b0);

        // Skip 5 leading samples after a fresh reset: beats are outputs #6..#13.
        apply_reset();
        run_vector(8, 5, 0, 1'b1, 1'b0);

        // Backpressure with a forced 10-cycle stall.
        run_vector(16, 2, 1, 1'b0, 1'b0);

        run_vector(1, 0, 0, 1'b1, 1'b0);
        run_vector(0, 3, 0, 1'b0, 1'b0);

        // Ignored mid-vector start, then a back-to-back vector continuing the sequence.
        run_vector(6, 2, 0, 1'b1, 1'b1);
        run_vector(4, 1, 0, 1'b1, 1'b0);

        // Reset while streaming with the FIFO full.
        tready_mode = 2;
        m_tready = 1'b0;
        start    = 1'b1;
        vec_len  = LW'(10);
        skip_len = SW'(0);
        t0 = cyc;
        en_cnt = 0;
        cur_skip = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_tvalid", int'(m_tvalid), 1);
        check("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        gen_idx = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tready_mode = 0;
        @(posedge clk);
        #1;
        check("after_reset_tvalid", int'(m_tvalid), 0);
        check("after_reset_done", int'(done), 0);
        run_vector(3, 0, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
